ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each access takes three cycles: IDLE, then ACCESS (one RAM cycle with exactly
// one enable high), then DONE (Ack pulse to the winning port). All RAM-side
// outputs and Acks are registered, so no input can reach Mem_Write
// combinationally.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Port A
  input  logic              A_Req,
  input  logic              A_Wr,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_WData,
  output logic              A_Ack,
  output logic [DATA_W-1:0] A_RData,
  // Port B
  input  logic              B_Req,
  input  logic              B_Wr,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_WData,
  output logic              B_Ack,
  output logic [DATA_W-1:0] B_RData,
  // RAM side
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state;
  logic              r_last_b;   // 1: port B was granted most recently, so A wins the next tie
  logic              r_win_b;    // winner of the access in flight (1 = B)
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_a_ack;
  logic              r_b_ack;

  logic              w_pick_b;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Pick the winner among the current requests and mux its command fields.
  // B wins when it is the only requester, or on a tie when A was granted last.
  always_comb begin
    w_pick_b    = B_Req && (!A_Req || !r_last_b);
    w_sel_wr    = w_pick_b ? B_Wr    : A_Wr;
    w_sel_addr  = w_pick_b ? B_Addr  : A_Addr;
    w_sel_wdata = w_pick_b ? B_WData : A_WData;
  end

  // Arbitration FSM. Reset aborts any access in flight without issuing an Ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b1;
      r_win_b   <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (A_Req || B_Req) begin
            r_win_b  <= w_pick_b;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_mem_wr <= w_sel_wr;
            r_mem_rd <= !w_sel_wr;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM read data is valid now, because Mem_Addr has been stable
          // for the whole cycle.
          if (r_mem_rd) begin
            if (r_win_b) r_b_rdata <= M_R_Data;
            else         r_a_rdata <= M_R_Data;
          end
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_a_ack  <= !r_win_b;
          r_b_ack  <= r_win_b;
          r_last_b <= r_win_b;
          r_state  <= DONE;
        end
        DONE: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_mem_rd <= 1'b0;
          r_mem_wr <= 1'b0;
          r_a_ack  <= 1'b0;
          r_b_ack  <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign Mem_Read  = r_mem_rd;
  assign Mem_Write = r_mem_wr;
  assign Mem_Addr  = r_addr;
  assign M_W_Data  = r_wdata;
  assign A_Ack     = r_a_ack;
  assign B_Ack     = r_b_ack;
  assign A_RData   = r_a_rdata;
  assign B_RData   = r_b_rdata;
  assign Busy      = (r_state != IDLE);

endmodule
